// File: rtl/fpu_div_exp_seq.sv
// fpu_div_exp_seq: exponent datapath for the iterative FP divide.
// Captures both operand exponents, forms the biased difference with denormal
// leading-zero correction, counts the fraction iterations, then applies
// quotient normalization and the rounding carry. The result is held under a
// start/done/ack handshake.
// Optional feature macro: FPU_DIV_EXP_EARLY_OF_EN (early overflow exit from SUB).
module fpu_div_exp_seq #(
  parameter int DP_ITERS = 55,
  parameter int SP_ITERS = 26
) (
  input  logic        rclk,
  input  logic        rst,
  input  logic        start,
  input  logic        dblop,
  input  logic [10:0] in1_exp,
  input  logic [10:0] in2_exp,
  input  logic [5:0]  in1_ld0,
  input  logic [5:0]  in2_ld0,
  input  logic        quo_msb,
  input  logic        frac_cout,
  input  logic        out_ack,
  output logic        busy,
  output logic [5:0]  iter_cnt,
  output logic        div_exp_done,
  output logic [10:0] div_exp_out,
  output logic        div_exp_of,
  output logic        div_exp_uf
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SUB  = 3'd1,
    S_ITER = 3'd2,
    S_NORM = 3'd3,
    S_RND  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic signed [12:0] DP_BIAS = 13'sd1023;
  localparam logic signed [12:0] SP_BIAS = 13'sd127;
  localparam logic signed [12:0] DP_MAX  = 13'sd2047;
  localparam logic signed [12:0] SP_MAX  = 13'sd255;
  localparam logic [5:0]         DP_LOAD = 6'(DP_ITERS - 1);
  localparam logic [5:0]         SP_LOAD = 6'(SP_ITERS - 1);

  // Select the exponent field for the precision and treat a zero (denormal)
  // field as 1, so the leading-zero count carries the rest of the correction.
  function automatic logic [10:0] op_field(input logic [10:0] raw, input logic dbl);
    logic [10:0] f;
    f = dbl ? raw : {3'b000, raw[10:3]};
    return (f == 11'd0) ? 11'd1 : f;
  endfunction

  state_t             state_q, state_d;
  logic               dbl_q, dbl_d;
  logic [10:0]        e1_q, e1_d;
  logic [10:0]        e2_q, e2_d;
  logic [5:0]         ld1_q, ld1_d;
  logic [5:0]         ld2_q, ld2_d;
  logic signed [12:0] exp_q, exp_d;
  logic [5:0]         iter_q, iter_d;
  logic [10:0]        out_q, out_d;
  logic               of_q, of_d;
  logic               uf_q, uf_d;

  logic signed [12:0] max_exp;
  logic signed [12:0] sub_exp;
  logic signed [12:0] rnd_exp;

  assign max_exp = dbl_q ? DP_MAX : SP_MAX;
  assign sub_exp = $signed({2'b00, e1_q}) - $signed({2'b00, e2_q})
                 - $signed({7'b0000000, ld1_q}) + $signed({7'b0000000, ld2_q})
                 + (dbl_q ? DP_BIAS : SP_BIAS);
  assign rnd_exp = exp_q + $signed({12'b0, frac_cout});

`ifdef FPU_DIV_EXP_EARLY_OF_EN
  // Even a normalization decrement cannot pull the exponent back below MAX.
  logic early_of;
  assign early_of = (sub_exp - 13'sd1) >= max_exp;
`endif

  // State and datapath registers; reset clears everything so no partial
  // result survives an abort.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dbl_q   <= 1'b0;
      e1_q    <= '0;
      e2_q    <= '0;
      ld1_q   <= '0;
      ld2_q   <= '0;
      exp_q   <= '0;
      iter_q  <= '0;
      out_q   <= '0;
      of_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dbl_q   <= dbl_d;
      e1_q    <= e1_d;
      e2_q    <= e2_d;
      ld1_q   <= ld1_d;
      ld2_q   <= ld2_d;
      exp_q   <= exp_d;
      iter_q  <= iter_d;
      out_q   <= out_d;
      of_q    <= of_d;
      uf_q    <= uf_d;
    end
  end

  // Next-state sequencing through SUB, the iteration window, NORM and RND.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_SUB;
`ifdef FPU_DIV_EXP_EARLY_OF_EN
      S_SUB:  state_d = early_of ? S_DONE : S_ITER;
`else
      S_SUB:  state_d = S_ITER;
`endif
      S_ITER: if (iter_q == 6'd0) state_d = S_NORM;
      S_NORM: state_d = S_RND;
      S_RND:  state_d = S_DONE;
      S_DONE: if (out_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates per state: capture, subtract, count, normalize, round.
  always_comb begin
    dbl_d  = dbl_q;
    e1_d   = e1_q;
    e2_d   = e2_q;
    ld1_d  = ld1_q;
    ld2_d  = ld2_q;
    exp_d  = exp_q;
    iter_d = iter_q;
    out_d  = out_q;
    of_d   = of_q;
    uf_d   = uf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dbl_d = dblop;
          e1_d  = op_field(in1_exp, dblop);
          e2_d  = op_field(in2_exp, dblop);
          ld1_d = in1_ld0;
          ld2_d = in2_ld0;
        end
      end
      S_SUB: begin
        exp_d = sub_exp;
`ifdef FPU_DIV_EXP_EARLY_OF_EN
        if (early_of) begin
          of_d  = 1'b1;
          out_d = max_exp[10:0];
        end else begin
          iter_d = dbl_q ? DP_LOAD : SP_LOAD;
        end
`else
        iter_d = dbl_q ? DP_LOAD : SP_LOAD;
`endif
      end
      S_ITER: begin
        if (iter_q != 6'd0) iter_d = iter_q - 6'd1;
      end
      S_NORM: begin
        if (!quo_msb) exp_d = exp_q - 13'sd1;
      end
      S_RND: begin
        exp_d = rnd_exp;
        if (rnd_exp >= max_exp) begin
          of_d  = 1'b1;
          out_d = max_exp[10:0];
        end else if (rnd_exp <= 13'sd0) begin
          uf_d  = 1'b1;
          out_d = 11'd0;
        end else begin
          out_d = rnd_exp[10:0];
        end
      end
      S_DONE: begin
        if (out_ack) begin
          exp_d = '0;
          out_d = '0;
          of_d  = 1'b0;
          uf_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Handshake outputs decoded from the state; result fields come from flops.
  always_comb begin
    busy         = (state_q != S_IDLE);
    div_exp_done = (state_q == S_DONE);
    iter_cnt     = iter_q;
    div_exp_out  = out_q;
    div_exp_of   = of_q;
    div_exp_uf   = uf_q;
  end

endmodule
